// File: rtl/mm_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mm_ctrl_pkg
//   Shared types and helpers for the matrix-multiply dispatch control path.
//   - dispatch_state_e : dispatch FSM states (IDLE, FEED, DONE)
//   - dispatch_cfg_t   : latched job descriptor
//   - cfg_is_legal()   : descriptor legality check
//   The CFG_* widths size the descriptor struct. Modules that carry a
//   dispatch_cfg_t must be built with matching width parameters.
// ---------------------------------------------------------------------------
package mm_ctrl_pkg;

   localparam int CFG_K_BITS    = 16;
   localparam int CFG_ROWS_BITS = 4;
   localparam int CFG_COLS_BITS = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FEED = 2'd1,
      DONE = 2'd2
   } dispatch_state_e;

   typedef struct packed {
      logic [CFG_K_BITS-1:0]  k_len;
      logic [CFG_ROWS_BITS:0] tile_rows;
      logic [CFG_COLS_BITS:0] tile_cols;
      logic                   output_by_row;
   } dispatch_cfg_t;

   // A job needs at least one beat per tile and a tile grid that fits
   // inside the physical processor array.
   function automatic logic cfg_is_legal(input dispatch_cfg_t c);
      logic [CFG_ROWS_BITS:0] rows_max;
      logic [CFG_COLS_BITS:0] cols_max;
      rows_max = {1'b1, {CFG_ROWS_BITS{1'b0}}};
      cols_max = {1'b1, {CFG_COLS_BITS{1'b0}}};
      return (c.k_len != '0) &&
             (c.tile_rows != '0) && (c.tile_rows <= rows_max) &&
             (c.tile_cols != '0) && (c.tile_cols <= cols_max);
   endfunction

endpackage

// File: rtl/tile_index_counter.sv
// ---------------------------------------------------------------------------
// tile_index_counter
//   Row-major tile address counter. Column advances first; at the last
//   used column it wraps to 0 and the row advances. Advancing from the
//   final tile returns both indices to 0.
// Ports
//   clk, reset   : clock, async active-high reset
//   i_clear      : synchronous return to tile (0,0)
//   i_advance    : step to the next tile
//   i_rows_m1    : index of the last used row
//   i_cols_m1    : index of the last used column
//   o_row, o_col : current tile address
//   o_final      : current tile is the last tile of the grid
// ---------------------------------------------------------------------------
module tile_index_counter #(
   parameter int ROWS_BITS = 4,
   parameter int COLS_BITS = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_clear,
   input  logic                 i_advance,
   input  logic [ROWS_BITS-1:0] i_rows_m1,
   input  logic [COLS_BITS-1:0] i_cols_m1,
   output logic [ROWS_BITS-1:0] o_row,
   output logic [COLS_BITS-1:0] o_col,
   output logic                 o_final
);

   logic [ROWS_BITS-1:0] r_row;
   logic [COLS_BITS-1:0] r_col;
   logic                 w_wrap;

   // Wrap flag: sitting on the last used column of the current row.
   assign w_wrap  = (r_col == i_cols_m1);
   assign o_final = w_wrap && (r_row == i_rows_m1);
   assign o_row   = r_row;
   assign o_col   = r_col;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_clear) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_advance) begin
         if (w_wrap) begin
            r_col <= '0;
            r_row <= o_final ? '0 : r_row + ROWS_BITS'(1);
         end else begin
            r_col <= r_col + COLS_BITS'(1);
         end
      end
   end

endmodule

// File: rtl/tile_dispatch_controller.sv
// ---------------------------------------------------------------------------
// tile_dispatch_controller
//   Sequences one C = A*B job over a grid of systolic tiles. After a legal
//   descriptor is accepted, paired A-column / B-row beats are forwarded to
//   the shared tile input bus, k_len beats per tile, tiles in row-major
//   order, with last marking each tile's final beat.
// Ports
//   clk, reset                      : clock, async active-high reset
//   cfg_valid/cfg_ready             : descriptor handshake (ready only in IDLE)
//   cfg_k_len, cfg_tile_rows/cols   : beats per tile, tile grid extent
//   cfg_output_by_row               : job output direction -> output_by_row
//   src_a_*/src_b_*                 : operand streams, consumed jointly
//   a_input_valid, b_input_valid    : beat valid toward tiles
//   input_row_id, input_col_id      : addressed tile
//   last                            : final beat of the addressed tile
//   a_data, b_data                  : combinational operand pass-through
//   input_ready                     : OR of tile readiness
//   busy, done, cfg_error           : job status; done/cfg_error are pulses
// ---------------------------------------------------------------------------
module tile_dispatch_controller
   import mm_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH          = 8,
   parameter int B_N                 = 4,
   parameter int PROCESSOR_ROWS_BITS = CFG_ROWS_BITS,
   parameter int PROCESSOR_COLS_BITS = CFG_COLS_BITS,
   parameter int K_BITS              = CFG_K_BITS
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              cfg_valid,
   output logic                              cfg_ready,
   input  logic [K_BITS-1:0]                 cfg_k_len,
   input  logic [PROCESSOR_ROWS_BITS:0]      cfg_tile_rows,
   input  logic [PROCESSOR_COLS_BITS:0]      cfg_tile_cols,
   input  logic                              cfg_output_by_row,
   input  logic                              src_a_valid,
   output logic                              src_a_ready,
   input  logic [(DATA_WIDTH<<B_N)-1:0]      src_a_data,
   input  logic                              src_b_valid,
   output logic                              src_b_ready,
   input  logic [(DATA_WIDTH<<B_N)-1:0]      src_b_data,
   output logic                              a_input_valid,
   output logic                              b_input_valid,
   output logic [PROCESSOR_ROWS_BITS-1:0]    input_row_id,
   output logic [PROCESSOR_COLS_BITS-1:0]    input_col_id,
   output logic                              last,
   output logic [(DATA_WIDTH<<B_N)-1:0]      a_data,
   output logic [(DATA_WIDTH<<B_N)-1:0]      b_data,
   input  logic                              input_ready,
   output logic                              output_by_row,
   output logic                              busy,
   output logic                              done,
   output logic                              cfg_error
);

   dispatch_state_e r_state;
   dispatch_state_e w_next_state;
   dispatch_cfg_t   r_cfg;
   dispatch_cfg_t   w_cfg_in;

   logic [K_BITS-1:0]              r_beat;
   logic                           r_cfg_error;
   logic                           w_idle;
   logic                           w_feed;
   logic                           w_legal;
   logic                           w_accept;
   logic                           w_pair_valid;
   logic                           w_beat_last;
   logic                           w_transfer;
   logic                           w_tile_end;
   logic                           w_final;
   logic [PROCESSOR_ROWS_BITS-1:0] w_rows_m1;
   logic [PROCESSOR_COLS_BITS-1:0] w_cols_m1;

   assign w_cfg_in = '{k_len:         cfg_k_len,
                       tile_rows:     cfg_tile_rows,
                       tile_cols:     cfg_tile_cols,
                       output_by_row: cfg_output_by_row};

   assign w_legal  = cfg_is_legal(w_cfg_in);
   assign w_accept = w_idle && cfg_valid && w_legal;

   // Descriptor extents are 1-based; the counters compare 0-based indices.
   // Legal extents are at most 2^BITS, so the truncation is lossless.
   assign w_rows_m1 = PROCESSOR_ROWS_BITS'(r_cfg.tile_rows - (PROCESSOR_ROWS_BITS+1)'(1));
   assign w_cols_m1 = PROCESSOR_COLS_BITS'(r_cfg.tile_cols - (PROCESSOR_COLS_BITS+1)'(1));

   // Valid is driven only from the sources, never from input_ready: tile
   // readiness itself depends on valid, so feeding it back would close a
   // combinational loop.
   assign w_pair_valid = src_a_valid && src_b_valid;
   assign w_beat_last  = (r_beat == r_cfg.k_len - K_BITS'(1));
   assign a_input_valid = w_feed && w_pair_valid;
   assign b_input_valid = a_input_valid;
   assign last          = a_input_valid && w_beat_last;
   assign w_transfer    = a_input_valid && input_ready;
   assign w_tile_end    = w_transfer && w_beat_last;

   // Both sources are popped together so A and B beats stay paired.
   assign src_a_ready = w_transfer;
   assign src_b_ready = w_transfer;

   assign a_data        = src_a_data;
   assign b_data        = src_b_data;
   assign output_by_row = r_cfg.output_by_row;
   assign cfg_error     = r_cfg_error;

   // -- FSM state register ---------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   // -- FSM next state and state-decoded outputs ------------------------------
   always_comb begin
      w_next_state = r_state;
      w_idle       = 1'b0;
      w_feed       = 1'b0;
      cfg_ready    = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         IDLE: begin
            w_idle    = 1'b1;
            cfg_ready = 1'b1;
            if (cfg_valid && w_legal) w_next_state = FEED;
         end
         FEED: begin
            w_feed = 1'b1;
            busy   = 1'b1;
            if (w_tile_end && w_final) w_next_state = DONE;
         end
         DONE: begin
            done         = 1'b1;
            w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // -- Descriptor latch, beat counter, error pulse ---------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cfg       <= '0;
         r_beat      <= '0;
         r_cfg_error <= 1'b0;
      end else begin
         // An illegal descriptor is still consumed (ready is high) so the
         // producer is not wedged; it is reported rather than executed.
         r_cfg_error <= w_idle && cfg_valid && !w_legal;
         if (w_accept) begin
            r_cfg  <= w_cfg_in;
            r_beat <= '0;
         end else if (w_transfer) begin
            r_beat <= w_beat_last ? '0 : r_beat + K_BITS'(1);
         end
      end
   end

   tile_index_counter #(
      .ROWS_BITS (PROCESSOR_ROWS_BITS),
      .COLS_BITS (PROCESSOR_COLS_BITS)
   ) u_tile_index_counter (
      .clk       (clk),
      .reset     (reset),
      .i_clear   (w_accept),
      .i_advance (w_tile_end),
      .i_rows_m1 (w_rows_m1),
      .i_cols_m1 (w_cols_m1),
      .o_row     (input_row_id),
      .o_col     (input_col_id),
      .o_final   (w_final)
   );

endmodule

// File: tb/tb_tile_dispatch_controller.sv
// ---------------------------------------------------------------------------
// tb_tile_dispatch_controller
//   Directed bench for tile_dispatch_controller. Inputs change just after
//   the falling edge; outputs are sampled 1 ns later, away from the rising
//   edge that commits state.
// ---------------------------------------------------------------------------
module tb_tile_dispatch_controller;

   localparam int DW = 8 << 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [15:0]   cfg_k_len;
   logic [4:0]    cfg_tile_rows;
   logic [4:0]    cfg_tile_cols;
   logic          cfg_output_by_row;
   logic          src_a_valid;
   logic          src_a_ready;
   logic [DW-1:0] src_a_data;
   logic          src_b_valid;
   logic          src_b_ready;
   logic [DW-1:0] src_b_data;
   logic          a_input_valid;
   logic          b_input_valid;
   logic [3:0]    input_row_id;
   logic [3:0]    input_col_id;
   logic          last;
   logic [DW-1:0] a_data;
   logic [DW-1:0] b_data;
   logic          input_ready;
   logic          output_by_row;
   logic          busy;
   logic          done;
   logic          cfg_error;

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   logic [DW-1:0] hold_a;
   logic [DW-1:0] hold_b;

   always #5 clk = ~clk;

   tile_dispatch_controller dut (
      .clk               (clk),
      .reset             (reset),
      .cfg_valid         (cfg_valid),
      .cfg_ready         (cfg_ready),
      .cfg_k_len         (cfg_k_len),
      .cfg_tile_rows     (cfg_tile_rows),
      .cfg_tile_cols     (cfg_tile_cols),
      .cfg_output_by_row (cfg_output_by_row),
      .src_a_valid       (src_a_valid),
      .src_a_ready       (src_a_ready),
      .src_a_data        (src_a_data),
      .src_b_valid       (src_b_valid),
      .src_b_ready       (src_b_ready),
      .src_b_data        (src_b_data),
      .a_input_valid     (a_input_valid),
      .b_input_valid     (b_input_valid),
      .input_row_id      (input_row_id),
      .input_col_id      (input_col_id),
      .last              (last),
      .a_data            (a_data),
      .b_data            (b_data),
      .input_ready       (input_ready),
      .output_by_row     (output_by_row),
      .busy              (busy),
      .done              (done),
      .cfg_error         (cfg_error)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd_beat();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Present a descriptor for one cycle; leaves the bench on the next
   // falling edge with the controller in FEED (or IDLE if illegal).
   task automatic send_cfg(input int k, input int rows, input int cols, input bit obr);
      cfg_valid         = 1'b1;
      cfg_k_len         = 16'(k);
      cfg_tile_rows     = 5'(rows);
      cfg_tile_cols     = 5'(cols);
      cfg_output_by_row = obr;
      #1;
      chk("cfg_ready_idle", DW'(cfg_ready), DW'(1));
      chk("no_valid_in_idle", DW'(a_input_valid), DW'(0));
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   // One accepted beat with the sources valid and the bus ready.
   task automatic beat(input string tag, input int row, input int col, input bit lst);
      hold_a     = rnd_beat();
      hold_b     = rnd_beat();
      src_a_data = hold_a;
      src_b_data = hold_b;
      #1;
      chk({tag, "_a_valid"}, DW'(a_input_valid), DW'(1));
      chk({tag, "_b_valid"}, DW'(b_input_valid), DW'(1));
      chk({tag, "_busy"}, DW'(busy), DW'(1));
      chk({tag, "_row"}, DW'(input_row_id), DW'(row));
      chk({tag, "_col"}, DW'(input_col_id), DW'(col));
      chk({tag, "_last"}, DW'(last), DW'(lst));
      chk({tag, "_a_ready"}, DW'(src_a_ready), DW'(1));
      chk({tag, "_b_ready"}, DW'(src_b_ready), DW'(1));
      chk({tag, "_a_data"}, a_data, hold_a);
      chk({tag, "_b_data"}, b_data, hold_b);
      chk({tag, "_no_done"}, DW'(done), DW'(0));
      @(negedge clk);
   endtask

   task automatic expect_done(input string tag);
      #1;
      chk({tag, "_done"}, DW'(done), DW'(1));
      chk({tag, "_busy_low"}, DW'(busy), DW'(0));
      chk({tag, "_no_valid"}, DW'(a_input_valid), DW'(0));
      chk({tag, "_not_ready"}, DW'(cfg_ready), DW'(0));
      @(negedge clk);
      #1;
      chk({tag, "_done_pulse"}, DW'(done), DW'(0));
      chk({tag, "_back_idle"}, DW'(cfg_ready), DW'(1));
      @(negedge clk);
   endtask

   initial begin
      reset             = 1'b1;
      cfg_valid         = 1'b0;
      cfg_k_len         = '0;
      cfg_tile_rows     = '0;
      cfg_tile_cols     = '0;
      cfg_output_by_row = 1'b0;
      src_a_valid       = 1'b0;
      src_b_valid       = 1'b0;
      src_a_data        = '0;
      src_b_data        = '0;
      input_ready       = 1'b0;

      // Reset state
      @(negedge clk);
      #1;
      chk("rst_cfg_ready", DW'(cfg_ready), DW'(1));
      chk("rst_busy", DW'(busy), DW'(0));
      chk("rst_done", DW'(done), DW'(0));
      chk("rst_cfg_error", DW'(cfg_error), DW'(0));
      chk("rst_a_valid", DW'(a_input_valid), DW'(0));
      chk("rst_b_valid", DW'(b_input_valid), DW'(0));
      chk("rst_last", DW'(last), DW'(0));
      chk("rst_row", DW'(input_row_id), DW'(0));
      chk("rst_col", DW'(input_col_id), DW'(0));
      chk("rst_obr", DW'(output_by_row), DW'(0));
      @(negedge clk);
      reset = 1'b0;

      // Single tile, k=3
      src_a_valid = 1'b1;
      src_b_valid = 1'b1;
      input_ready = 1'b1;
      send_cfg(3, 1, 1, 1'b1);
      #1;
      chk("t1_obr_latched", DW'(output_by_row), DW'(1));
      beat("t1_b0", 0, 0, 1'b0);
      beat("t1_b1", 0, 0, 1'b0);
      beat("t1_b2", 0, 0, 1'b1);
      expect_done("t1");

      // 2x2 grid, k=2, row-major order
      send_cfg(2, 2, 2, 1'b0);
      for (int t = 0; t < 4; t++) begin
         beat("t2_first", t / 2, t % 2, 1'b0);
         beat("t2_second", t / 2, t % 2, 1'b1);
      end
      expect_done("t2");

      // B source stalls mid-tile, k=4
      send_cfg(4, 1, 1, 1'b0);
      beat("t3_b0", 0, 0, 1'b0);
      beat("t3_b1", 0, 0, 1'b0);
      src_b_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t3_stall_a_valid", DW'(a_input_valid), DW'(0));
         chk("t3_stall_b_valid", DW'(b_input_valid), DW'(0));
         chk("t3_stall_a_ready", DW'(src_a_ready), DW'(0));
         chk("t3_stall_last", DW'(last), DW'(0));
         chk("t3_stall_busy", DW'(busy), DW'(1));
         @(negedge clk);
      end
      src_b_valid = 1'b1;
      beat("t3_b2", 0, 0, 1'b0);
      beat("t3_b3", 0, 0, 1'b1);
      expect_done("t3");

      // Bus not ready for 5 cycles on the last beat of tile (0,0)
      send_cfg(2, 1, 2, 1'b0);
      beat("t4_b0", 0, 0, 1'b0);
      input_ready = 1'b0;
      hold_a      = rnd_beat();
      hold_b      = rnd_beat();
      src_a_data  = hold_a;
      src_b_data  = hold_b;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t4_hold_valid", DW'(a_input_valid), DW'(1));
         chk("t4_hold_last", DW'(last), DW'(1));
         chk("t4_hold_col", DW'(input_col_id), DW'(0));
         chk("t4_hold_a_ready", DW'(src_a_ready), DW'(0));
         chk("t4_hold_b_ready", DW'(src_b_ready), DW'(0));
         chk("t4_hold_a_data", a_data, hold_a);
         @(negedge clk);
      end
      input_ready = 1'b1;
      #1;
      chk("t4_release_last", DW'(last), DW'(1));
      chk("t4_release_ready", DW'(src_a_ready), DW'(1));
      @(negedge clk);
      beat("t4_t1_b0", 0, 1, 1'b0);
      beat("t4_t1_b1", 0, 1, 1'b1);
      expect_done("t4");

      // Illegal descriptors: k=0, cols=0, rows beyond the array
      send_cfg(0, 1, 1, 1'b1);
      #1;
      chk("t5_k0_error", DW'(cfg_error), DW'(1));
      chk("t5_k0_busy", DW'(busy), DW'(0));
      chk("t5_k0_valid", DW'(a_input_valid), DW'(0));
      chk("t5_k0_obr", DW'(output_by_row), DW'(0));
      @(negedge clk);
      #1;
      chk("t5_k0_error_pulse", DW'(cfg_error), DW'(0));
      chk("t5_k0_idle", DW'(cfg_ready), DW'(1));
      @(negedge clk);
      send_cfg(1, 1, 0, 1'b0);
      #1;
      chk("t5_c0_error", DW'(cfg_error), DW'(1));
      chk("t5_c0_idle", DW'(cfg_ready), DW'(1));
      @(negedge clk);
      send_cfg(1, 17, 1, 1'b0);
      #1;
      chk("t5_r17_error", DW'(cfg_error), DW'(1));
      chk("t5_r17_busy", DW'(busy), DW'(0));
      @(negedge clk);
      send_cfg(1, 1, 1, 1'b0);
      #1;
      chk("t5_legal_no_error", DW'(cfg_error), DW'(0));
      beat("t5_k1", 0, 0, 1'b1);
      expect_done("t5");

      // Async reset during beat 1 of tile (0,1)
      send_cfg(2, 1, 2, 1'b1);
      beat("t6_b0", 0, 0, 1'b0);
      beat("t6_b1", 0, 0, 1'b1);
      beat("t6_t1_b0", 0, 1, 1'b0);
      #1;
      chk("t6_pre_col", DW'(input_col_id), DW'(1));
      chk("t6_pre_last", DW'(last), DW'(1));
      reset = 1'b1;
      #1;
      chk("t6_rst_valid", DW'(a_input_valid), DW'(0));
      chk("t6_rst_b_valid", DW'(b_input_valid), DW'(0));
      chk("t6_rst_last", DW'(last), DW'(0));
      chk("t6_rst_row", DW'(input_row_id), DW'(0));
      chk("t6_rst_col", DW'(input_col_id), DW'(0));
      chk("t6_rst_a_ready", DW'(src_a_ready), DW'(0));
      chk("t6_rst_cfg_ready", DW'(cfg_ready), DW'(1));
      chk("t6_rst_busy", DW'(busy), DW'(0));
      chk("t6_rst_obr", DW'(output_by_row), DW'(0));
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      #1;
      chk("t6_post_idle", DW'(cfg_ready), DW'(1));
      chk("t6_post_busy", DW'(busy), DW'(0));
      chk("t6_post_done", DW'(done), DW'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Safety net so a wedged run still ends with a report.
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

endmodule
